ms_tmr_mc: RTL and testbench

Next-generation timer/PWM core. Parametrised counter width and N compare/PWM channels, with prescaler, up / down / center-aligned modes, one-shot operation and shadowed (glitch-free) period/compare reload. Bus-agnostic: an APB/WB wrapper drives the configuration inputs and the RIS/IM/ICR logic from the flag pulses.

---
 rtl/ms_tmr_pkg.sv | 25 ++
 rtl/ms_tmr_mc_if.sv | 38 +++
 rtl/ms_tmr_ch.sv | 48 ++++
 rtl/ms_tmr_mc.sv | 185 ++++++++++++++++++
 tb/tb_ms_tmr_mc.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ms_tmr_pkg.sv
// Shared encodings for the ms_tmr_mc timer/PWM core: count modes, FSM states, channel slicing.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package ms_tmr_pkg;

    // Count direction modes; 2'b11 behaves exactly like MODE_UP.
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_CENTER = 2'b10,
        MODE_UP_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // LSB of channel ch inside a flat NCH*W compare bus.
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/ms_tmr_mc_if.sv
// Configuration/status bundle of the timer core: master = bus wrapper, slave = timer.
// Latency: n/a (wires only). Backpressure: none, all signals are level or single-cycle pulses.
// Ports: en/tmr_en/mode/one_shot/prescale/period/cmp/pwm_en/pwm_inv/restart in; tmr/dir/running/pwm/flags out.
interface ms_tmr_mc_if #(
    parameter int W     = 32,
    parameter int NCH   = 4,
    parameter int PSC_W = 8
);
    logic             en_i;
    logic             tmr_en_i;
    logic [1:0]       mode_i;
    logic             one_shot_i;
    logic [PSC_W-1:0] prescale_i;
    logic [W-1:0]     period_i;
    logic [NCH*W-1:0] cmp_i;
    logic [NCH-1:0]   pwm_en_i;
    logic [NCH-1:0]   pwm_inv_i;
    logic             restart_i;

    logic [W-1:0]     tmr_o;
    logic             dir_o;
    logic             running_o;
    logic [NCH-1:0]   pwm_o;
    logic             to_flag_o;
    logic [NCH-1:0]   cmp_flag_o;

    modport master (
        output en_i, tmr_en_i, mode_i, one_shot_i, prescale_i, period_i,
               cmp_i, pwm_en_i, pwm_inv_i, restart_i,
        input  tmr_o, dir_o, running_o, pwm_o, to_flag_o, cmp_flag_o
    );

    modport slave (
        input  en_i, tmr_en_i, mode_i, one_shot_i, prescale_i, period_i,
               cmp_i, pwm_en_i, pwm_inv_i, restart_i,
        output tmr_o, dir_o, running_o, pwm_o, to_flag_o, cmp_flag_o
    );
endinterface

// File: rtl/ms_tmr_ch.sv
// One compare/PWM channel: shadowed compare value, match pulse and registered PWM output.
// Latency: cmp_flag coincides with the matching count; pwm lags the count by one clock.
// Backpressure: none. Ports: load/cmp_in shadow reload, cnt_chg/tmr_nxt count step, tmr_cur/run for PWM.
module ms_tmr_ch #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load,
    input  logic [W-1:0] cmp_in,
    input  logic         cnt_chg,
    input  logic [W-1:0] tmr_nxt,
    input  logic [W-1:0] tmr_cur,
    input  logic         run,
    input  logic         pwm_en,
    input  logic         pwm_inv,
    output logic         cmp_flag,
    output logic         pwm
);
    logic [W-1:0] cmp_sh;
    logic [W-1:0] cmp_eff;
    logic         raw;

    // A reload and a count step can land on the same edge (wrap); the
    // match must use the compare value that governs the new period.
    assign cmp_eff = load ? cmp_in : cmp_sh;
    assign raw     = run & (tmr_cur < cmp_sh);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_sh   <= '0;
            cmp_flag <= 1'b0;
            pwm      <= 1'b0;
        end else if (!en_i) begin
            // Soft reset parks the output at its idle (inverted) level.
            cmp_sh   <= '0;
            cmp_flag <= 1'b0;
            pwm      <= pwm_en & pwm_inv;
        end else begin
            if (load) begin
                cmp_sh <= cmp_in;
            end
            cmp_flag <= cnt_chg & (tmr_nxt == cmp_eff);
            pwm      <= pwm_en & (raw ^ pwm_inv);
        end
    end
endmodule

// File: rtl/ms_tmr_mc.sv
// Timer/PWM core: prescaled up/down/center counter with one-shot, shadowed period and NCH PWM channels.
// Latency: to_flag one clock after the terminal tick; pwm one clock after tmr_o.
// Backpressure: none. Ports: clk_i, rst_i (sync, active-high) and the slave side of ms_tmr_mc_if.
module ms_tmr_mc
    import ms_tmr_pkg::*;
#(
    parameter int W     = 32,
    parameter int NCH   = 4,
    parameter int PSC_W = 8
) (
    input logic        clk_i,
    input logic        rst_i,
    ms_tmr_mc_if.slave bus
);
    localparam logic [W-1:0]     ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] ONE_PSC = {{(PSC_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    mode_e            mode;
    logic [PSC_W-1:0] psc_q;
    logic [W-1:0]     tmr_q, per_sh_q;
    logic             dir_q, to_flag_q;

    logic             tick;
    logic [W-1:0]     tmr_inc, tmr_dec, tmr_step, tmr_hold;
    logic             dir_step, term_raw;
    logic             start, step, term, hold;
    logic             shadow_load, cnt_chg, in_run;
    logic [NCH-1:0]   pwm_vec, cmp_flag_vec;

    assign mode    = mode_e'(bus.mode_i);
    assign tick    = (psc_q == bus.prescale_i);
    assign tmr_inc = tmr_q + ONE_W;
    assign tmr_dec = tmr_q - ONE_W;
    assign in_run  = (state_q == ST_RUN);

    // Count value/direction one tick would produce, plus whether that tick is terminal.
    always_comb begin
        tmr_step = tmr_q;
        dir_step = dir_q;
        term_raw = 1'b0;
        case (mode)
            MODE_DOWN: begin
                dir_step = 1'b1;
                if (tmr_q == '0) begin
                    // Down reload takes the live period input, which is also the new shadow.
                    tmr_step = bus.period_i;
                    term_raw = 1'b1;
                end else begin
                    tmr_step = tmr_dec;
                end
            end
            MODE_CENTER: begin
                if (per_sh_q == '0) begin
                    tmr_step = '0;
                    dir_step = 1'b0;
                    term_raw = 1'b1;
                end else if (!dir_q) begin
                    // Direction flips on arrival at the peak.
                    tmr_step = tmr_inc;
                    dir_step = (tmr_inc == per_sh_q);
                end else if (tmr_q <= ONE_W) begin
                    // Arrival at the valley ends the period.
                    tmr_step = '0;
                    dir_step = 1'b0;
                    term_raw = 1'b1;
                end else begin
                    tmr_step = tmr_dec;
                end
            end
            default: begin
                dir_step = 1'b0;
                if (tmr_q >= per_sh_q) begin
                    tmr_step = '0;
                    term_raw = 1'b1;
                end else begin
                    tmr_step = tmr_inc;
                end
            end
        endcase
    end

    // Control FSM: stop beats restart, restart beats a (terminal) tick.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        term    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.tmr_en_i) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.tmr_en_i) begin
                    state_d = ST_IDLE;
                end else if (bus.restart_i) begin
                    start = 1'b1;
                end else if (tick) begin
                    step = 1'b1;
                    if (term_raw) begin
                        term = 1'b1;
                        if (bus.one_shot_i) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!bus.tmr_en_i) begin
                    state_d = ST_IDLE;
                end else if (bus.restart_i) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-shot freezes on the terminal value: the peak for up, zero otherwise.
    assign hold        = term & bus.one_shot_i;
    assign tmr_hold    = (mode == MODE_CENTER) ? '0 : tmr_q;
    assign shadow_load = start | term;
    assign cnt_chg     = step & ~hold & (tmr_step != tmr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.en_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.en_i) begin
            psc_q     <= '0;
            tmr_q     <= '0;
            per_sh_q  <= '0;
            dir_q     <= 1'b0;
            to_flag_q <= 1'b0;
        end else begin
            to_flag_q <= term;
            psc_q     <= (start || tick || state_d != ST_RUN) ? '0 : psc_q + ONE_PSC;
            if (start) begin
                per_sh_q <= bus.period_i;
                tmr_q    <= (mode == MODE_DOWN) ? bus.period_i : '0;
                dir_q    <= (mode == MODE_DOWN);
            end else if (step) begin
                tmr_q <= hold ? tmr_hold : tmr_step;
                dir_q <= dir_step;
                if (term) begin
                    per_sh_q <= bus.period_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        ms_tmr_ch #(.W(W)) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (bus.en_i),
            .load     (shadow_load),
            .cmp_in   (bus.cmp_i[ch_lsb(g, W) +: W]),
            .cnt_chg  (cnt_chg),
            .tmr_nxt  (tmr_step),
            .tmr_cur  (tmr_q),
            .run      (in_run),
            .pwm_en   (bus.pwm_en_i[g]),
            .pwm_inv  (bus.pwm_inv_i[g]),
            .cmp_flag (cmp_flag_vec[g]),
            .pwm      (pwm_vec[g])
        );
    end

    assign bus.tmr_o      = tmr_q;
    assign bus.dir_o      = dir_q;
    assign bus.running_o  = in_run;
    assign bus.to_flag_o  = to_flag_q;
    assign bus.pwm_o      = pwm_vec;
    assign bus.cmp_flag_o = cmp_flag_vec;
endmodule

// File: tb/tb_ms_tmr_mc.sv
// Self-checking bench for ms_tmr_mc: period-position reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
// Ports: drives the master side of ms_tmr_mc_if directly.
module tb_ms_tmr_mc;
    localparam int W     = 16;
    localparam int NCH   = 2;
    localparam int PSC_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ms_tmr_mc_if #(.W(W), .NCH(NCH), .PSC_W(PSC_W)) bus ();
    ms_tmr_mc #(.W(W), .NCH(NCH), .PSC_W(PSC_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The period is a position 0..L-1 advanced on prescaler ticks; the count
    // and direction are pure functions of (mode, period, position).
    int             m_state = 0;   // 0 idle, 1 run, 2 done
    int             m_pos = 0, m_per = 0, m_psc = 0, m_tmr = 0;
    int             m_cmp[NCH];
    bit             m_dir = 0, m_to = 0;
    bit [NCH-1:0]   m_cf = '0, m_pwm = '0;

    function automatic int plen(input int mode, input int per);
        if (mode == 2) return (per == 0) ? 1 : 2 * per;
        return per + 1;
    endfunction

    function automatic int pos_tmr(input int mode, input int per, input int pos);
        if (mode == 1) return per - pos;
        if (mode == 2) return (pos <= per) ? pos : 2 * per - pos;
        return pos;
    endfunction

    function automatic bit pos_dir(input int mode, input int per, input int pos);
        if (mode == 1) return 1'b1;
        if (mode == 2) return (per != 0) && (pos >= per);
        return 1'b0;
    endfunction

    task automatic load_shadows();
        m_per = int'(bus.period_i);
        for (int c = 0; c < NCH; c++) m_cmp[c] = int'(bus.cmp_i[c*W +: W]);
    endtask

    task automatic model_clear();
        m_state = 0; m_psc = 0; m_pos = 0; m_per = 0; m_tmr = 0; m_dir = 0;
        for (int c = 0; c < NCH; c++) m_cmp[c] = 0;
    endtask

    task automatic model_start(input int mode);
        m_state = 1; m_psc = 0; m_pos = 0;
        load_shadows();
        m_tmr = pos_tmr(mode, m_per, 0);
        m_dir = pos_dir(mode, m_per, 0);
    endtask

    task automatic model_adv(input int mode);
        int old_tmr;
        int np;
        old_tmr = m_tmr;
        np = m_pos + 1;
        if (np >= plen(mode, m_per)) begin
            m_to = 1'b1;
            load_shadows();
            if (bus.one_shot_i) begin
                m_state = 2;
                if (mode == 2) begin
                    m_tmr = 0;
                    m_dir = 1'b0;
                end
                return;
            end
            m_pos = 0;
        end else begin
            m_pos = np;
        end
        m_tmr = pos_tmr(mode, m_per, m_pos);
        m_dir = pos_dir(mode, m_per, m_pos);
        if (m_tmr != old_tmr)
            for (int c = 0; c < NCH; c++) m_cf[c] = (m_tmr == m_cmp[c]);
    endtask

    always @(posedge clk) begin : model_p
        int mode;
        bit [NCH-1:0] raw;
        mode = int'(bus.mode_i);
        for (int c = 0; c < NCH; c++) raw[c] = (m_state == 1) && (m_tmr < m_cmp[c]);
        m_to = 1'b0;
        m_cf = '0;
        if (rst) begin
            model_clear();
            m_pwm = '0;
        end else if (!bus.en_i) begin
            model_clear();
            m_pwm = bus.pwm_inv_i & bus.pwm_en_i;
        end else begin
            m_pwm = bus.pwm_en_i & (raw ^ bus.pwm_inv_i);
            case (m_state)
                0: if (bus.tmr_en_i) model_start(mode);
                1: begin
                    if (!bus.tmr_en_i) begin
                        m_state = 0;
                        m_psc = 0;
                    end else if (bus.restart_i) begin
                        model_start(mode);
                    end else if (m_psc == int'(bus.prescale_i)) begin
                        m_psc = 0;
                        model_adv(mode);
                    end else begin
                        m_psc++;
                    end
                end
                default: begin
                    if (!bus.tmr_en_i) m_state = 0;
                    else if (bus.restart_i) model_start(mode);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("m_tmr",  32'(bus.tmr_o),      32'(m_tmr));
        chk("m_dir",  32'(bus.dir_o),      32'(m_dir));
        chk("m_run",  32'(bus.running_o),  32'(m_state == 1));
        chk("m_to",   32'(bus.to_flag_o),  32'(m_to));
        chk("m_cf",   32'(bus.cmp_flag_o), 32'(m_cf));
        chk("m_pwm",  32'(bus.pwm_o),      32'(m_pwm));
    end

    // ---------------- directed expectations ----------------
    int t1_tmr[11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    int t1_to [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t1_pwm[11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int t1_cf [11] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    int t2_tmr[9]  = '{3, 3, 2, 2, 1, 1, 0, 0, 3};
    int t2_to [9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int t3_tmr[11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int t3_dir[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    int t3_to [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int t3_pwm[11] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    int t4_tmr[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 0};
    int t4_to [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t4_cf [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int t5_tmr[5]  = '{0, 1, 2, 2, 2};
    int t5_run[5]  = '{1, 1, 1, 0, 0};
    int t5_to [5]  = '{0, 0, 0, 1, 0};

    task automatic stop_tmr();
        bus.tmr_en_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.en_i = 1'b0;      bus.tmr_en_i = 1'b0;  bus.mode_i = 2'b00;
        bus.one_shot_i = 1'b0; bus.prescale_i = '0; bus.period_i = '0;
        bus.cmp_i = '0;       bus.pwm_en_i = '0;    bus.pwm_inv_i = '0;
        bus.restart_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tmr", 32'(bus.tmr_o), 0);
        chk("rst_run", 32'(bus.running_o), 0);
        chk("rst_pwm", 32'(bus.pwm_o), 0);

        // 1: up, period 4, cmp0 2
        rst = 1'b0; bus.en_i = 1'b1; bus.period_i = 16'd4;
        bus.cmp_i = {16'd3, 16'd2}; bus.pwm_en_i = 2'b01; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("t1_tmr", 32'(bus.tmr_o), t1_tmr[i]);
            chk("t1_to",  32'(bus.to_flag_o), t1_to[i]);
            chk("t1_pwm", 32'(bus.pwm_o[0]), t1_pwm[i]);
            chk("t1_cf",  32'(bus.cmp_flag_o[0]), t1_cf[i]);
        end

        // 2: down, period 3, prescale 1
        stop_tmr();
        bus.mode_i = 2'b01; bus.period_i = 16'd3; bus.prescale_i = 4'd1; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t2_tmr", 32'(bus.tmr_o), t2_tmr[i]);
            chk("t2_to",  32'(bus.to_flag_o), t2_to[i]);
            chk("t2_dir", 32'(bus.dir_o), 1);
        end

        // 3: center, period 3, cmp0 2
        stop_tmr();
        bus.mode_i = 2'b10; bus.prescale_i = '0; bus.cmp_i = {16'd3, 16'd2}; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("t3_tmr", 32'(bus.tmr_o), t3_tmr[i]);
            chk("t3_dir", 32'(bus.dir_o), t3_dir[i]);
            chk("t3_to",  32'(bus.to_flag_o), t3_to[i]);
            chk("t3_pwm", 32'(bus.pwm_o[0]), t3_pwm[i]);
        end

        // 4: shadowed reload mid-period
        stop_tmr();
        bus.mode_i = 2'b00; bus.period_i = 16'd9; bus.cmp_i = {16'd0, 16'd5}; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t4_tmr", 32'(bus.tmr_o), t4_tmr[i]);
            chk("t4_to",  32'(bus.to_flag_o), t4_to[i]);
            chk("t4_cf",  32'(bus.cmp_flag_o[0]), t4_cf[i]);
            if (i == 3) begin
                bus.period_i = 16'd4;
                bus.cmp_i = {16'd0, 16'd1};
            end
        end

        // 5: one-shot up, period 2
        stop_tmr();
        bus.one_shot_i = 1'b1; bus.period_i = 16'd2; bus.cmp_i = {16'd3, 16'd1};
        bus.pwm_en_i = 2'b11; bus.pwm_inv_i = 2'b01; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_tmr", 32'(bus.tmr_o), t5_tmr[i]);
            chk("t5_run", 32'(bus.running_o), t5_run[i]);
            chk("t5_to",  32'(bus.to_flag_o), t5_to[i]);
        end
        chk("t5_pwm_done", 32'(bus.pwm_o), 32'h1);
        stop_tmr();
        chk("t5_idle_hold", 32'(bus.tmr_o), 2);
        bus.tmr_en_i = 1'b1;
        @(negedge clk);
        chk("t5_rearm_tmr", 32'(bus.tmr_o), 0);
        chk("t5_rearm_run", 32'(bus.running_o), 1);

        // 6: restart on terminal tick, reset, soft reset, duty extremes
        bus.one_shot_i = 1'b0;
        stop_tmr();
        bus.pwm_en_i = 2'b01; bus.pwm_inv_i = 2'b00; bus.period_i = 16'd4;
        bus.cmp_i = {16'd0, 16'd2}; bus.tmr_en_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_pre_tmr", 32'(bus.tmr_o), 4);
        bus.restart_i = 1'b1;
        @(negedge clk);
        bus.restart_i = 1'b0;
        chk("t6_rs_to",  32'(bus.to_flag_o), 0);
        chk("t6_rs_tmr", 32'(bus.tmr_o), 0);
        repeat (2) @(negedge clk);
        bus.pwm_inv_i = 2'b01; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tmr", 32'(bus.tmr_o), 0);
        chk("t6_rst_run", 32'(bus.running_o), 0);
        chk("t6_rst_pwm", 32'(bus.pwm_o), 0);
        rst = 1'b0; bus.en_i = 1'b0;
        @(negedge clk);
        chk("t6_soft_pwm", 32'(bus.pwm_o), 32'h1);
        chk("t6_soft_run", 32'(bus.running_o), 0);
        bus.en_i = 1'b1; bus.pwm_inv_i = 2'b00;
        stop_tmr();
        bus.period_i = 16'd9; bus.cmp_i = {16'd0, 16'd0}; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_cmp0_pwm", 32'(bus.pwm_o[0]), 0);
        end
        stop_tmr();
        bus.cmp_i = {16'd0, 16'd12}; bus.tmr_en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_cmp12_pwm", 32'(bus.pwm_o[0]), (i >= 1) ? 1 : 0);
        end

        // full-range period in down mode
        stop_tmr();
        bus.mode_i = 2'b01; bus.period_i = 16'hFFFF; bus.tmr_en_i = 1'b1;
        @(negedge clk);
        chk("fr_tmr0", 32'(bus.tmr_o), 32'hFFFF);
        @(negedge clk);
        chk("fr_tmr1", 32'(bus.tmr_o), 32'hFFFE);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
